// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: producer handshake, flush handshake,
// RAM write port, pointer exchange with the read domain and status flags.
interface fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_req_in;
   logic                  wr_ready_out;
   logic                  flush_req_in;
   logic                  flush_done_out;
   logic [ADDR_WIDTH:0]   rd_gptr_in;
   logic                  mem_we_out;
   logic [ADDR_WIDTH-1:0] wr_addr_out;
   logic [ADDR_WIDTH:0]   wr_gptr_out;
   logic                  full_out;
   logic                  almost_full_out;
   logic [ADDR_WIDTH:0]   level_out;
   logic                  overflow_out;

   // Producer / environment side.
   modport master (
      output wr_req_in, flush_req_in, rd_gptr_in,
      input  wr_ready_out, flush_done_out, mem_we_out, wr_addr_out, wr_gptr_out,
             full_out, almost_full_out, level_out, overflow_out
   );

   // Controller side.
   modport slave (
      input  wr_req_in, flush_req_in, rd_gptr_in,
      output wr_ready_out, flush_done_out, mem_we_out, wr_addr_out, wr_gptr_out,
             full_out, almost_full_out, level_out, overflow_out
   );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO: owns the binary and
// Gray write pointers, synchronises the read Gray pointer, derives full,
// almost-full and level, and sequences start-up settling and drain/flush.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 2
) (
   input  logic          clk,
   input  logic          rst_n_in,
   fifo_wr_ctrl_if.slave bus
);
   localparam int            PW          = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AFULL_LEVEL = PW'((1 << ADDR_WIDTH) - AFULL_THRESH);
   localparam logic [PW-1:0] ONE         = PW'(1);

   typedef enum logic [1:0] {INIT, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [1:0]    settle_cnt;
   logic [PW-1:0] wr_bin;
   logic [PW-1:0] wr_gptr;
   logic [PW-1:0] next_bin;
   logic [PW-1:0] rd_gptr_p1;
   logic [PW-1:0] rd_gsync;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] level;
   logic          full;
   logic          empty;
   logic          ready;
   logic          accept;
   logic          overflow;
   logic          flush_done;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Flags are derived only from registered state, never from inputs.
   // Full means the write pointer is exactly one lap ahead of the read pointer,
   // which in Gray code is the top two bits inverted.
   assign rd_bin   = gray2bin(rd_gsync);
   assign level    = wr_bin - rd_bin;
   assign full     = (wr_gptr == {~rd_gsync[PW-1:PW-2], rd_gsync[PW-3:0]});
   assign empty    = (rd_gsync == wr_gptr);
   assign ready    = (state == RUN) && !full;
   assign accept   = bus.wr_req_in && ready;
   assign next_bin = wr_bin + ONE;

   assign bus.wr_ready_out    = ready;
   assign bus.mem_we_out      = accept;
   assign bus.wr_addr_out     = wr_bin[ADDR_WIDTH-1:0];
   assign bus.wr_gptr_out     = wr_gptr;
   assign bus.full_out        = full;
   assign bus.almost_full_out = (level >= AFULL_LEVEL);
   assign bus.level_out       = level;
   assign bus.overflow_out    = overflow;
   assign bus.flush_done_out  = flush_done;

   // Two-flop synchroniser bringing the read Gray pointer into this domain.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_gptr_p1 <= '0;
         rd_gsync   <= '0;
      end else begin
         rd_gptr_p1 <= bus.rd_gptr_in;
         rd_gsync   <= rd_gptr_p1;
      end
   end

   // Advance the write pointer on each accepted push; Gray copy kept registered.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_bin  <= '0;
         wr_gptr <= '0;
      end else if (accept) begin
         wr_bin  <= next_bin;
         wr_gptr <= bin2gray(next_bin);
      end
   end

   // Sticky overflow: a push attempted while running and full.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         overflow <= 1'b0;
      end else if ((state == RUN) && bus.wr_req_in && full) begin
         overflow <= 1'b1;
      end
   end

   // Control FSM: settle after reset, run, drain on flush, pulse done.
   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= INIT;
         settle_cnt <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         unique case (state)
            INIT: begin
               settle_cnt <= settle_cnt + 2'd1;
               if (settle_cnt == 2'd1) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.flush_req_in) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Pointers are left alone: the read side owns its own pointer.
               if (empty) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE: begin
               state <= RUN;
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed phases plus a random phase, every cycle
// compared with an occupancy-based reference model kept as plain integers.
module tb_fifo_wr_ctrl;
   localparam int AW    = 4;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam int THR   = 2;
   localparam int P_INIT = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   logic clk = 1'b0;
   logic rst_n;

   fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
      .clk      (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad   = 0;
   string tag_s = "start";

   // Reference model: absolute push/pop counts and the two-edge view of the
   // read pointer as seen by the write side.
   int wr_abs, rd_abs;
   int s1, s2;
   int phase, init_edges, m_ovf, m_done;
   int prev_wr;

   function automatic int gray(input int n);
      int m;
      m = n % (2 * DEPTH);
      return m ^ (m >> 1);
   endfunction

   function automatic int ungray(input int g);
      for (int k = 0; k < 2 * DEPTH; k++) begin
         if (gray(k) == g) return k;
      end
      return -1;
   endfunction

   function automatic int m_level();
      return ((wr_abs - ungray(s2)) % (2 * DEPTH) + 2 * DEPTH) % (2 * DEPTH);
   endfunction

   task automatic model_reset();
      wr_abs = 0; rd_abs = 0; s1 = 0; s2 = 0;
      phase = P_INIT; init_edges = 0; m_ovf = 0; m_done = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s/%s observed=%0d expected=%0d", tag_s, name, obs, exp);
      end
   endtask

   task automatic compare_all();
      int lvl;
      bit mfull, rdy;
      lvl   = m_level();
      mfull = (lvl == DEPTH);
      rdy   = (phase == P_RUN) && !mfull;
      chk("ready",   32'(bus.wr_ready_out),    32'(rdy));
      chk("mem_we",  32'(bus.mem_we_out),      32'(rdy && (bus.wr_req_in === 1'b1)));
      chk("addr",    32'(bus.wr_addr_out),     32'(wr_abs % DEPTH));
      chk("gptr",    32'(bus.wr_gptr_out),     32'(gray(wr_abs)));
      chk("full",    32'(bus.full_out),        32'(mfull));
      chk("afull",   32'(bus.almost_full_out), 32'(lvl >= DEPTH - THR));
      chk("level",   32'(bus.level_out),       32'(lvl));
      chk("ovf",     32'(bus.overflow_out),    32'(m_ovf));
      chk("fdone",   32'(bus.flush_done_out),  32'(m_done));
   endtask

   task automatic model_edge(input bit req, input bit fl);
      int lvl, nphase;
      bit mfull, rdy;
      lvl    = m_level();
      mfull  = (lvl == DEPTH);
      rdy    = (phase == P_RUN) && !mfull;
      nphase = phase;
      m_done = (phase == P_DRAIN && lvl == 0) ? 1 : 0;
      if (phase == P_RUN && req && mfull) m_ovf = 1;
      case (phase)
         P_INIT:  begin init_edges++; if (init_edges >= 2) nphase = P_RUN; end
         P_RUN:   if (fl) nphase = P_DRAIN;
         P_DRAIN: if (lvl == 0) nphase = P_DONE;
         default: nphase = P_RUN;
      endcase
      if (req && rdy) wr_abs++;
      s2    = s1;
      s1    = gray(rd_abs);
      phase = nphase;
   endtask

   // One clock cycle: drive inputs while clk is low, compare, advance model.
   task automatic step(input bit req, input bit fl);
      bus.wr_req_in    = req;
      bus.flush_req_in = fl;
      bus.rd_gptr_in   = PW'(gray(rd_abs));
      #1;
      compare_all();
      model_edge(req, fl);
      @(negedge clk);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.wr_req_in    = 1'b0;
      bus.flush_req_in = 1'b0;
      bus.rd_gptr_in   = '0;
      model_reset();
      @(negedge clk);
      #1;
      tag_s = "reset";
      compare_all();

      // Settling after reset release
      @(negedge clk);
      rst_n = 1'b1;
      tag_s = "init";
      repeat (4) step(1'b0, 1'b0);

      // Fill with the reader idle
      tag_s = "fill";
      repeat (16) step(1'b1, 1'b0);
      #1;
      chk("full16_level", 32'(bus.level_out),   32'd16);
      chk("full16_full",  32'(bus.full_out),    32'd1);
      chk("full16_gptr",  32'(bus.wr_gptr_out), 32'b11000);

      // Push into a full FIFO, then free one slot
      tag_s = "ovf";
      repeat (3) step(1'b1, 1'b0);
      chk("ovf_set", 32'(bus.overflow_out), 32'd1);
      tag_s = "free";
      rd_abs = 1;
      repeat (4) step(1'b1, 1'b0);

      // Reader catches up
      tag_s = "catch";
      while (rd_abs < wr_abs) begin
         rd_abs++;
         step(1'b0, 1'b0);
      end
      repeat (3) step(1'b0, 1'b0);

      // Wrap-around with the reader trailing closely
      tag_s = "wrap";
      prev_wr = wr_abs;
      for (int i = 0; i < 40; i++) begin
         rd_abs  = prev_wr;
         prev_wr = wr_abs;
         step(1'b1, 1'b0);
         chk("wrap_nofull", 32'(bus.full_out), 32'd0);
         chk("wrap_lvl3",   32'(bus.level_out <= 5'd3), 32'd1);
      end

      // Flush while running, pushes ignored, then reader drains
      tag_s = "flush";
      rd_abs = prev_wr;
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      rd_abs = wr_abs;
      repeat (5) step(1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0);

      // Asynchronous reset in the middle of a drain at level 5
      tag_s = "pre_rst";
      rd_abs = wr_abs;
      repeat (3) step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      tag_s = "async_rst";
      compare_all();
      chk("rst_level0", 32'(bus.level_out), 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         compare_all();
      end
      @(negedge clk);
      rst_n = 1'b1;
      tag_s = "init2";
      repeat (3) step(1'b0, 1'b0);
      chk("init2_addr", 32'(bus.wr_addr_out), 32'd0);

      // Flush with no prior overflow, then immediate re-drain
      tag_s = "flush2";
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0);
      chk("flush2_noovf", 32'(bus.overflow_out), 32'd0);
      rd_abs = wr_abs;
      repeat (8) step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);

      // Random traffic
      tag_s = "rand";
      for (int i = 0; i < 300; i++) begin
         if (rd_abs < wr_abs && $urandom_range(0, 1) == 1) rd_abs++;
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side pointer controller for the asynchronous FIFO. It owns the write pointer in binary and Gray form, synchronises the read-domain Gray pointer, and generates full, almost-full and level. It handshakes push requests against full and drives the dual-port RAM write address and write enable. An FSM sequences start-up settling and a drain-and-flush handshake.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AFULL_THRESH, 2, almost_full_out asserts when free slots <= AFULL_THRESH; legal range 0..2^ADDR_WIDTH-1.

Ports:
clk  in  1  write-domain clock.
rst_n_in  in  1  asynchronous active-low reset.
wr_req_in  in  1  push request from the producer.
wr_ready_out  out  1  controller can accept a push this cycle.
flush_req_in  in  1  level-sensitive; starts a drain sequence.
rd_gptr_in  in  ADDR_WIDTH+1  Gray read pointer from the read domain, unsynchronised.
mem_we_out  out  1  RAM write enable; combinational, equal to wr_req_in & wr_ready_out.
wr_addr_out  out  ADDR_WIDTH  RAM write address, equal to wr_bin[ADDR_WIDTH-1:0].
wr_gptr_out  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
full_out  out  1  FIFO full as seen from the write side.
almost_full_out  out  1  free slots <= AFULL_THRESH.
level_out  out  ADDR_WIDTH+1  occupancy as seen from the write side.
overflow_out  out  1  sticky error flag.
flush_done_out  out  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset: clk is the single clock; rst_n_in is asynchronous and active-low.
  - On reset, the following clear to 0 immediately with no clock required: wr_bin, wr_gptr_out, both synchroniser stages, overflow_out, flush_done_out and the settle counter.
  - The FSM goes to INIT.
  - Consequently wr_ready_out=0, mem_we_out=0, full_out=0, almost_full_out=0 and level_out=0 while reset is held.
- Synchroniser:
  - rd_gptr_in passes through two flops to give rd_gsync; latency is 2 clk edges.
  - rd_gsync is converted combinationally from Gray to binary as rd_bin.
  - rd_gptr_in is Gray-coded and changes at most one bit per read-domain edge.
- Write pointer:
  - accept = wr_req_in & wr_ready_out.
  - On an accept edge, wr_bin <= wr_bin+1 (mod 2^(ADDR_WIDTH+1)) and wr_gptr_out <= next_bin ^ (next_bin>>1).
  - wr_gptr_out is therefore always the registered Gray code of wr_bin, with no combinational path to the output.
  - Wrap-around from all-ones to 0 is natural with no special case; the Gray value goes from 1 followed by zeros to 0.
- Flags: all are combinational from registered wr_gptr_out, wr_bin and rd_gsync, with no input-to-output path.
  - full_out = (wr_gptr_out == {~rd_gsync[MSB:MSB-1], rd_gsync[MSB-2:0]}).
  - level_out = wr_bin - rd_bin, mod 2^(ADDR_WIDTH+1), range 0..2^ADDR_WIDTH.
  - almost_full_out = (level_out >= 2^ADDR_WIDTH - AFULL_THRESH).
  - Flags are pessimistic: a read is seen only after 2 cycles of synchroniser latency. A write is seen in the same cycle the pointer register updates.
- FSM states: INIT, RUN, DRAIN, DONE.
  - INIT: wr_ready_out=0; a 2-bit counter lets the synchroniser settle. After 2 clk edges out of reset, go to RUN.
  - RUN: wr_ready_out = ~full_out. If flush_req_in=1, go to DRAIN.
  - DRAIN: wr_ready_out=0; wr_req_in is ignored and does not set overflow. When level_out==0 (rd_gsync == wr_gptr_out), go to DONE.
  - DONE: flush_done_out=1 for exactly this cycle; wr_ready_out=0; go to RUN on the next edge. A flush does not reset pointers, because the read side owns its own pointer.
- Simultaneous events:
  - wr_req_in and flush_req_in in the same RUN cycle with ready=1: the write is accepted, then the FSM enters DRAIN.
  - flush_req_in still high when DONE returns to RUN: a new drain starts one cycle later; an immediate re-drain is legal.
  - A write that makes the FIFO full and a read that frees a slot in the same cycle: full_out is seen for at least 2 cycles. This is intended.
- Overflow:
  - overflow_out is set on an edge where state==RUN, wr_req_in=1 and full_out=1.
  - It is cleared only by reset. The pointer and RAM are untouched.
- Reset mid-operation (any state, including DRAIN): asynchronous return to the reset values above, then INIT. flush_done_out does not pulse.

Test Plan:
1. Release reset with rd_gptr_in=0 (ADDR_WIDTH=4, AFULL_THRESH=2) -> wr_ready_out=0 for 2 edges, then 1; all flags 0; level_out=0.
2. 16 back-to-back pushes with rd_gptr_in held at 0 -> wr_addr_out runs 0..15 and mem_we_out pulses 16 times. wr_gptr_out runs 00000,00001,00011,00010,... and ends at 11000. almost_full_out=1 once level_out=14. full_out=1 with level_out=16 and wr_ready_out=0.
3. From full, hold wr_req_in=1 -> overflow_out=1 and sticks, wr_gptr_out unchanged. Then drive rd_gptr_in=00001 -> full_out clears 2 edges later, one push is accepted at wr_addr_out=0, and overflow_out stays 1.
4. Wrap: 40 pushes with rd_gptr_in tracking wr_gptr_out, delayed 3 cycles -> wr_bin wraps 31 to 0 and wr_gptr_out goes 10000 to 00000. full_out never asserts; level_out stays <= 3.
5. Flush at level 3 -> wr_ready_out drops the next cycle, and wr_req_in pulses cause no write and no overflow. Set rd_gptr_in equal to wr_gptr_out -> after 2 synchroniser edges the FSM enters DONE, flush_done_out is high for exactly 1 cycle, and RUN resumes with the pointer preserved.
6. Assert rst_n_in between clock edges while in DRAIN at level 5 -> all outputs 0 with no clock edge. After release, INIT lasts 2 edges and wr_addr_out=0.
